// File: rtl/ram_march_bist_pkg.sv
// Shared types and March C- element tables for the RAM BIST initiator.
// Bit e of each ELEM_* mask describes element Me.
package ram_march_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        FIN
    } state_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // Elements M3..M5 walk the address space downwards.
    localparam logic [7:0] ELEM_DOWN   = 8'b0011_1000;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_RD_BG  = 8'b0001_0100;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
    localparam logic [7:0] ELEM_WR_BG  = 8'b0000_1010;

    function automatic logic [2:0] next_elem(input logic [2:0] e);
        return e + 3'd1;
    endfunction

endpackage

// File: rtl/ram_march_addr_gen.sv
// Up/down address counter for one March element: reloads at element start,
// steps once per completed address and flags the element's final address.
module ram_march_addr_gen #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  dir_down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= dir_down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    assign last = dir_down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port RAM with asynchronous read data.
// One RAM operation per cycle; stops on the first read mismatch.
module ram_march_bist #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    import ram_march_bist_pkg::*;

    state_t          state_reg;
    logic [2:0]      elem_reg;
    logic [2:0]      elem_next;
    logic [2:0]      wr_follow_elem;
    logic            ag_load;
    logic            ag_load_down;
    logic            ag_step;
    logic            ag_last;
    logic [DATA_WIDTH-1:0] rd_expect;
    logic            mismatch;

    assign elem_next      = next_elem(elem_reg);
    // A write always finishes an address, so the op after it belongs to the
    // next element when the address was the element's last.
    assign wr_follow_elem = ag_last ? elem_next : elem_reg;
    assign rd_expect      = {DATA_WIDTH{ELEM_RD_BG[elem_reg]}};
    assign mismatch       = (state_reg == RD) && (mem_dout != rd_expect);

    always_comb begin
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state_reg)
            IDLE: ag_load = start;
            WR: begin
                if (ag_last) begin
                    ag_load      = 1'b1;
                    ag_load_down = ELEM_DOWN[elem_next];
                end else begin
                    ag_step = 1'b1;
                end
            end
            RD:      ag_step = !mismatch && !ELEM_HAS_WR[elem_reg] && !ag_last;
            default: ;
        endcase
    end

    ram_march_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .load_down(ag_load_down),
        .step     (ag_step),
        .dir_down (ELEM_DOWN[elem_reg]),
        .addr     (mem_addr),
        .last     (ag_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            elem_reg  <= M0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_elem <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            mem_we    <= 1'b0;
            mem_din   <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= WR;
                        elem_reg  <= M0;
                        busy      <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_din   <= {DATA_WIDTH{ELEM_WR_BG[M0]}};
                        pass      <= 1'b0;
                        fail_elem <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
                WR: begin
                    if (ag_last) begin
                        elem_reg <= elem_next;
                    end
                    if (ELEM_HAS_RD[wr_follow_elem]) begin
                        state_reg <= RD;
                        mem_we    <= 1'b0;
                    end else begin
                        state_reg <= WR;
                        mem_we    <= 1'b1;
                        mem_din   <= {DATA_WIDTH{ELEM_WR_BG[wr_follow_elem]}};
                    end
                end
                RD: begin
                    if (mismatch) begin
                        state_reg <= FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_we    <= 1'b0;
                        pass      <= 1'b0;
                        fail_elem <= elem_reg;
                        fail_addr <= mem_addr;
                        fail_data <= mem_dout;
                    end else if (ELEM_HAS_WR[elem_reg]) begin
                        state_reg <= WR;
                        mem_we    <= 1'b1;
                        mem_din   <= {DATA_WIDTH{ELEM_WR_BG[elem_reg]}};
                    end else if (ag_last) begin
                        // Only the final read-only element reaches here.
                        state_reg <= FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b1;
                    end
                end
                FIN:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
